mc_control_fsm: RTL and testbench

MC_CONTROL_FSM -- requirements
Module: mc_control_fsm

---
 rtl/mc_pkg.sv | 44 ++++
 rtl/mc_control_fsm.sv | 154 +++++++++++++++
 tb/tb_mc_control_fsm.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mc_pkg.sv
// Shared definitions for the multi-cycle MIPS control FSM: state encoding,
// opcodes, and the datapath select encodings driven by the controller.
package mc_pkg;

   typedef enum logic [3:0] {
      ST_FETCH  = 4'd0,
      ST_DECODE = 4'd1,
      ST_MEMADR = 4'd2,
      ST_MEMRD  = 4'd3,
      ST_MEMWB  = 4'd4,
      ST_MEMWR  = 4'd5,
      ST_EXEC   = 4'd6,
      ST_ALUWB  = 4'd7,
      ST_BRANCH = 4'd8,
      ST_JUMP   = 4'd9,
      ST_ADDIEX = 4'd10,
      ST_ADDIWB = 4'd11
   } mc_state_t;

   // Opcodes (instruction[31:26]) understood by the controller.
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;

   // ALU operation selects.
   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;

   // ALU B-operand selects.
   localparam logic [1:0] SRCB_REG     = 2'b00;
   localparam logic [1:0] SRCB_CONST4  = 2'b01;
   localparam logic [1:0] SRCB_IMM     = 2'b10;
   localparam logic [1:0] SRCB_IMM_SL2 = 2'b11;

   // Next-PC source selects.
   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_control_fsm.sv
// Multi-cycle MIPS control unit. One state register; all datapath controls
// decode combinationally from the current state (and mem_ready for the
// memory-wait states). Reset forces every control low.
module mc_control_fsm
   import mc_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   input  logic [5:0] opcode,
   input  logic       mem_ready,
   output logic       pc_write,
   output logic       pc_write_cond,
   output logic       iord,
   output logic       mem_read,
   output logic       mem_write,
   output logic       ir_write,
   output logic       mem_to_reg,
   output logic       reg_dst,
   output logic       reg_write,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic [1:0] pc_source,
   output logic       illegal_op,
   output logic [3:0] state_dbg
);

   mc_state_t state;
   mc_state_t next_state;
   // Remembers whether the decoded memory instruction was a store, so the
   // MEMADR exit does not depend on opcode after DECODE.
   logic      is_store;

   assign state_dbg = state;

   // State register plus the lw/sw flag captured during DECODE.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= ST_FETCH;
         is_store <= 1'b0;
      end else begin
         state <= next_state;
         if (state == ST_DECODE) begin
            is_store <= (opcode == OP_SW);
         end
      end
   end

   // Next-state and control decode; reset overrides every output to 0.
   always_comb begin
      next_state    = ST_FETCH;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      iord          = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      mem_to_reg    = 1'b0;
      reg_dst       = 1'b0;
      reg_write     = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = SRCB_REG;
      alu_op        = ALU_ADD;
      pc_source     = PCSRC_ALU;
      illegal_op    = 1'b0;
      case (state)
         ST_FETCH: begin
            mem_read   = 1'b1;
            alu_src_b  = SRCB_CONST4;
            ir_write   = mem_ready;
            pc_write   = mem_ready;
            next_state = mem_ready ? ST_DECODE : ST_FETCH;
         end
         ST_DECODE: begin
            alu_src_b = SRCB_IMM_SL2;
            case (opcode)
               OP_RTYPE:     next_state = ST_EXEC;
               OP_LW, OP_SW: next_state = ST_MEMADR;
               OP_BEQ:       next_state = ST_BRANCH;
               OP_J:         next_state = ST_JUMP;
               OP_ADDI:      next_state = ST_ADDIEX;
               default: begin
                  next_state = ST_FETCH;
                  illegal_op = 1'b1;
               end
            endcase
         end
         ST_MEMADR: begin
            alu_src_a  = 1'b1;
            alu_src_b  = SRCB_IMM;
            next_state = is_store ? ST_MEMWR : ST_MEMRD;
         end
         ST_MEMRD: begin
            mem_read   = 1'b1;
            iord       = 1'b1;
            next_state = mem_ready ? ST_MEMWB : ST_MEMRD;
         end
         ST_MEMWB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
         end
         ST_MEMWR: begin
            mem_write  = 1'b1;
            iord       = 1'b1;
            next_state = mem_ready ? ST_FETCH : ST_MEMWR;
         end
         ST_EXEC: begin
            alu_src_a  = 1'b1;
            alu_op     = ALU_FUNCT;
            next_state = ST_ALUWB;
         end
         ST_ALUWB: begin
            reg_write = 1'b1;
            reg_dst   = 1'b1;
         end
         ST_BRANCH: begin
            alu_src_a     = 1'b1;
            alu_op        = ALU_SUB;
            pc_write_cond = 1'b1;
            pc_source     = PCSRC_ALUOUT;
         end
         ST_JUMP: begin
            pc_write  = 1'b1;
            pc_source = PCSRC_JUMP;
         end
         ST_ADDIEX: begin
            alu_src_a  = 1'b1;
            alu_src_b  = SRCB_IMM;
            next_state = ST_ADDIWB;
         end
         ST_ADDIWB: begin
            reg_write = 1'b1;
         end
         default: next_state = ST_FETCH;
      endcase
      if (reset) begin
         pc_write      = 1'b0;
         pc_write_cond = 1'b0;
         iord          = 1'b0;
         mem_read      = 1'b0;
         mem_write     = 1'b0;
         ir_write      = 1'b0;
         mem_to_reg    = 1'b0;
         reg_dst       = 1'b0;
         reg_write     = 1'b0;
         alu_src_a     = 1'b0;
         alu_src_b     = 2'b00;
         alu_op        = 2'b00;
         pc_source     = 2'b00;
         illegal_op    = 1'b0;
      end
   end

endmodule

// File: tb/tb_mc_control_fsm.sv
// Bench for mc_control_fsm: each instruction is modelled as the list of
// states it walks through; memory states repeat while mem_ready is low.
module tb_mc_control_fsm;
   import mc_pkg::*;

   logic       clk;
   logic       reset;
   logic [5:0] opcode;
   logic       mem_ready;
   logic       pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
   logic       mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
   logic [1:0] alu_src_b, alu_op, pc_source;
   logic [3:0] state_dbg;

   int checks;
   int failures;

   mc_state_t seq[$];

   logic [16:0] ctrl_vec;
   assign ctrl_vec = {pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
                      mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
                      pc_source, illegal_op};

   mc_control_fsm dut (
      .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
      .pc_write(pc_write), .pc_write_cond(pc_write_cond), .iord(iord),
      .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
      .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
      .pc_source(pc_source), .illegal_op(illegal_op), .state_dbg(state_dbg)
   );

   // Clock generation.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard time limit so the run always ends.
   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
      $fatal(1, "timeout");
   end

   function automatic bit op_legal(input logic [5:0] op);
      return (op == 6'b000000) || (op == 6'b100011) || (op == 6'b101011) ||
             (op == 6'b000100) || (op == 6'b000010) || (op == 6'b001000);
   endfunction

   function automatic int base_cycles(input logic [5:0] op);
      case (op)
         6'b000100, 6'b000010:            return 3;
         6'b000000, 6'b101011, 6'b001000: return 4;
         6'b100011:                       return 5;
         default:                         return 2;
      endcase
   endfunction

   // State path of one instruction with memory always ready.
   task automatic build_seq(input logic [5:0] op);
      seq = {};
      seq.push_back(ST_FETCH);
      seq.push_back(ST_DECODE);
      case (op)
         6'b000000: begin seq.push_back(ST_EXEC);   seq.push_back(ST_ALUWB);  end
         6'b100011: begin seq.push_back(ST_MEMADR); seq.push_back(ST_MEMRD); seq.push_back(ST_MEMWB); end
         6'b101011: begin seq.push_back(ST_MEMADR); seq.push_back(ST_MEMWR); end
         6'b000100: seq.push_back(ST_BRANCH);
         6'b000010: seq.push_back(ST_JUMP);
         6'b001000: begin seq.push_back(ST_ADDIEX); seq.push_back(ST_ADDIWB); end
         default: ;
      endcase
   endtask

   // Expected control vector for a state, from the control table.
   function automatic logic [16:0] exp_ctrl(input mc_state_t st, input logic mr,
                                            input logic [5:0] op);
      logic pcw, pcwc, io, mrd, mwr, irw, m2r, rdst, rw, sa, ill;
      logic [1:0] sb, ao, ps;
      {pcw, pcwc, io, mrd, mwr, irw, m2r, rdst, rw, sa, ill} = '0;
      sb = 2'b00; ao = 2'b00; ps = 2'b00;
      case (st)
         ST_FETCH:  begin mrd = 1; sb = 2'b01; irw = mr; pcw = mr; end
         ST_DECODE: begin sb = 2'b11; ill = !op_legal(op); end
         ST_MEMADR: begin sa = 1; sb = 2'b10; end
         ST_MEMRD:  begin mrd = 1; io = 1; end
         ST_MEMWB:  begin rw = 1; m2r = 1; end
         ST_MEMWR:  begin mwr = 1; io = 1; end
         ST_EXEC:   begin sa = 1; ao = 2'b10; end
         ST_ALUWB:  begin rw = 1; rdst = 1; end
         ST_BRANCH: begin sa = 1; ao = 2'b01; pcwc = 1; ps = 2'b01; end
         ST_JUMP:   begin pcw = 1; ps = 2'b10; end
         ST_ADDIEX: begin sa = 1; sb = 2'b10; end
         ST_ADDIWB: begin rw = 1; end
         default: ;
      endcase
      return {pcw, pcwc, io, mrd, mwr, irw, m2r, rdst, rw, sa, sb, ao, ps, ill};
   endfunction

   // Runs one instruction starting at a negedge with the DUT in FETCH.
   // fs = stalled FETCH cycles, ms = stalled MEMRD/MEMWR cycles.
   task automatic run_instr(input logic [5:0] op, input int fs, input int ms, input string name);
      int idx, fs_left, ms_left, measured, rw, mw, il, exp_lat, exp_rw, exp_mw;
      bit left;
      mc_state_t st;
      logic mr;
      logic [16:0] exp_c;
      bit has_mem;
      idx = 0; fs_left = fs; ms_left = ms; measured = -1; rw = 0; mw = 0; il = 0; left = 0;
      has_mem = (op == 6'b100011) || (op == 6'b101011);
      build_seq(op);
      for (int k = 0; k < 40; k++) begin
         if (k > 0) @(negedge clk);
         if (left && state_dbg == ST_FETCH) begin
            measured = k;
            break;
         end
         st = (idx < seq.size()) ? seq[idx] : ST_FETCH;
         mr = 1'b1;
         if (st == ST_FETCH && fs_left > 0) begin
            mr = 1'b0; fs_left--;
         end else if ((st == ST_MEMRD || st == ST_MEMWR) && ms_left > 0) begin
            mr = 1'b0; ms_left--;
         end
         opcode = op;
         mem_ready = mr;
         #1;
         checks++;
         if (state_dbg !== st) begin
            failures++;
            $display("FAIL %s state cyc%0d: got %0d expected %0d", name, k, state_dbg, st);
         end
         exp_c = exp_ctrl(st, mr, op);
         checks++;
         if (ctrl_vec !== exp_c) begin
            failures++;
            $display("FAIL %s ctrl cyc%0d: got %b expected %b", name, k, ctrl_vec, exp_c);
         end
         checks++;
         if (int'(reg_write) + int'(mem_write) + int'(pc_write) > 1) begin
            failures++;
            $display("FAIL %s exclusive cyc%0d: rw=%b mw=%b pw=%b expected at most one",
                     name, k, reg_write, mem_write, pc_write);
         end
         rw += int'(reg_write);
         mw += int'(mem_write);
         il += int'(illegal_op);
         if (state_dbg != ST_FETCH) left = 1;
         if (mr || !(st == ST_FETCH || st == ST_MEMRD || st == ST_MEMWR)) idx++;
      end
      exp_lat = base_cycles(op) + fs + (has_mem ? ms : 0);
      exp_rw  = (op == 6'b000000 || op == 6'b100011 || op == 6'b001000) ? 1 : 0;
      exp_mw  = (op == 6'b101011) ? 1 + ms : 0;
      checks++;
      if (measured !== exp_lat) begin
         failures++;
         $display("FAIL %s latency: got %0d expected %0d", name, measured, exp_lat);
      end
      checks++;
      if (rw !== exp_rw) begin
         failures++;
         $display("FAIL %s reg_write count: got %0d expected %0d", name, rw, exp_rw);
      end
      checks++;
      if (mw !== exp_mw) begin
         failures++;
         $display("FAIL %s mem_write count: got %0d expected %0d", name, mw, exp_mw);
      end
      checks++;
      if (il !== (op_legal(op) ? 0 : 1)) begin
         failures++;
         $display("FAIL %s illegal_op count: got %0d expected %0d", name, il, op_legal(op) ? 0 : 1);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      mem_ready = 1'b1;
      opcode = 6'($urandom_range(0, 63));
      #1;
      checks++;
      if (state_dbg !== ST_FETCH) begin
         failures++;
         $display("FAIL reset state: got %0d expected %0d", state_dbg, ST_FETCH);
      end
      checks++;
      if (ctrl_vec !== 17'd0) begin
         failures++;
         $display("FAIL reset outputs: got %b expected 0", ctrl_vec);
      end
      @(negedge clk);
      checks++;
      if (ctrl_vec !== 17'd0 || state_dbg !== ST_FETCH) begin
         failures++;
         $display("FAIL reset held: ctrl %b state %0d expected 0 and FETCH", ctrl_vec, state_dbg);
      end
      reset = 1'b0;
   endtask

   task automatic test_rtype();
      run_instr(6'b000000, 0, 0, "rtype");
   endtask

   task automatic test_lw_stall();
      run_instr(6'b100011, 0, 2, "lw_stall");
   endtask

   task automatic test_sw();
      run_instr(6'b101011, 0, 0, "sw");
   endtask

   task automatic test_branch_jump();
      run_instr(6'b000100, 0, 0, "beq");
      run_instr(6'b000010, 0, 0, "j");
   endtask

   task automatic test_illegal();
      run_instr(6'b111111, 0, 0, "illegal");
   endtask

   task automatic test_back_to_back();
      logic [5:0] ops[6];
      logic [5:0] op;
      ops[0] = 6'b000000; ops[1] = 6'b100011; ops[2] = 6'b101011;
      ops[3] = 6'b000100; ops[4] = 6'b000010; ops[5] = 6'b001000;
      for (int n = 0; n < 60; n++) begin
         if ($urandom_range(0, 6) == 0) op = 6'($urandom_range(0, 63));
         else op = ops[$urandom_range(0, 5)];
         run_instr(op, $urandom_range(0, 2), $urandom_range(0, 3), "random");
      end
   endtask

   task automatic test_reset_in_memwr();
      opcode = 6'b101011;
      mem_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      mem_ready = 1'b0;
      #1;
      checks++;
      if (state_dbg !== ST_MEMWR || mem_write !== 1'b1) begin
         failures++;
         $display("FAIL memwr reach: state %0d mem_write %b expected %0d and 1",
                  state_dbg, mem_write, ST_MEMWR);
      end
      reset = 1'b1;
      #1;
      checks++;
      if (ctrl_vec !== 17'd0 || state_dbg !== ST_FETCH) begin
         failures++;
         $display("FAIL async reset: ctrl %b state %0d expected 0 and FETCH", ctrl_vec, state_dbg);
      end
      @(negedge clk);
      reset = 1'b0;
      mem_ready = 1'b1;
      #1;
      checks++;
      if (state_dbg !== ST_FETCH || mem_read !== 1'b1 || ir_write !== 1'b1) begin
         failures++;
         $display("FAIL post reset fetch: state %0d mem_read %b ir_write %b expected FETCH,1,1",
                  state_dbg, mem_read, ir_write);
      end
      @(negedge clk);
      checks++;
      if (state_dbg !== ST_DECODE) begin
         failures++;
         $display("FAIL post reset decode: got %0d expected %0d", state_dbg, ST_DECODE);
      end
   endtask

   initial begin
      checks = 0;
      failures = 0;
      reset = 1'b1;
      opcode = 6'd0;
      mem_ready = 1'b0;
      test_reset();
      test_rtype();
      test_lw_stall();
      test_sw();
      test_branch_jump();
      test_illegal();
      test_back_to_back();
      test_reset_in_memwr();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
